load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sequencer that sits directly upstream of the byte-addressed data memory and is the only block that drives its port. It accepts load/store requests from the execute stage over a valid/ready handshake and forms the effective address. It checks size, alignment and range, sequences the memory's two-edge read latency and one-edge write, and extends load data. It returns a registered response (data + fault code) over a valid/ready handshake.

Parameters:
MEM_BYTES, 256, bytes implemented in the memory; accesses touching byte >= MEM_BYTES fault.
ALLOW_MISALIGNED, 0, 1 = skip alignment check (the memory handles unaligned bytes itself).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready at an edge
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads: sign-extend (1) or zero-extend (0)
req_base  in  32  base register value
req_offset  in  32  offset (already sign-extended by decode)
req_wdata  in  32  store data, low bytes used per size
resp_valid  out  1  response present
resp_ready  in  1  response consumed when valid&ready at an edge
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  2  00 none, 01 misaligned, 10 out_of_range, 11 bad_size
memory_address  out  32  to memory
memory_in  out  32  to memory
memory_size  out  2  to memory
memory_write_enable  out  1  to memory
memory_out  in  32  from memory

Behaviour:
- States: IDLE, WRITE, RD0, RD1, RD2, RESP. req_ready = (state==IDLE) & !rst.
- Accept (IDLE, req_valid): addr = req_base + req_offset mod 2^32. Register memory_address=addr, memory_size=req_size, memory_in=req_wdata. These stay stable until the next accept.
- Fault check at accept, priority bad_size > misaligned > out_of_range.
  - misaligned (ALLOW_MISALIGNED=0): half with addr[0]=1; word with addr[1:0]!=0.
  - out_of_range: 33-bit addr + nbytes > MEM_BYTES, where nbytes = 1/2/4.
- Fault: next state RESP with resp_fault set and resp_rdata=0. No memory access; memory_write_enable is never asserted.
- Store, no fault: next state WRITE. memory_write_enable=1 for exactly that one cycle, so the memory commits at WRITE's closing edge. Then RESP with rdata=0 and fault=00. Latency: accept edge -> resp_valid 2 cycles later.
- Load, no fault: RD0 -> RD1 -> RD2, with memory_write_enable=0 throughout.
  - Memory stages bytes at end of RD0 and updates memory_out at end of RD1.
  - In RD2, resp_rdata <= extend(memory_out), then go to RESP.
  - resp_valid rises 4 cycles after the accept edge.
- Extension: byte uses bit7, half uses bit15 when req_signed; otherwise zero-fill. Word passes through unchanged.
- RESP: resp_valid=1 and outputs hold stable until resp_ready. The handshake edge moves to IDLE. No request is accepted in the same cycle as response handshake (one transaction in flight).
- memory_write_enable is a registered output, high only in WRITE.
- Reset values: resp_valid=0, resp_rdata=0, resp_fault=00, memory_address=0, memory_in=0, memory_size=00, memory_write_enable=0, state=IDLE.
- Reset mid-transaction: transaction is dropped and no response is produced.
  - A store whose WRITE cycle coincides with the reset edge still commits, since memory samples write_enable at that edge.
  - Loads abandoned by reset have no side effects.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package lsu_pkg: size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD), fault enum (FAULT_NONE, FAULT_MISALIGNED, FAULT_RANGE, FAULT_BAD_SIZE), state enum, nbytes-from-size function.
- One combinational sub-module, load_extend: (memory_out, size, signed) -> 32-bit result. It is also reusable by the future cache path.

Test Plan:
- Store word base=0x10 off=0x4 wdata=0xDEADBEEF -> write_enable high exactly one cycle, address 0x14, size 10. Then load word same address, unsigned -> resp_rdata=0xDEADBEEF, resp_valid 4 cycles after accept.
- Store byte 0x80 at 0x20, then load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080. Load half signed 0x21:0x20 after storing 0x7FFF at 0x20 -> 0x00007FFF.
- Faults: load half at 0x21 -> fault 01, no memory activity. Load word at 0xFE -> fault 11 if size=11, else 01 (misaligned wins); word at 0x100 -> 10; byte base=0xFFFFFFFF off=1 (wraps to 0) -> fault 00, valid access. All fault responses arrive 1 cycle after accept.
- Backpressure: hold resp_ready=0 for 5 cycles on a load -> resp_valid, rdata and fault stay stable; req_ready=0 and new req_valid ignored; after handshake, next request accepted the following cycle.
- Reset in RD1 of a load -> next cycle resp_valid=0, IDLE, req_ready=1, all memory_* outputs 0. Reset coinciding with a WRITE cycle -> subsequent load shows the stored value.
- ALLOW_MISALIGNED=1: store word 0x11223344 at 0x03, load word -> 0x11223344, fault 00.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, fault codes, FSM states
// and the registered memory-request / response payloads.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_MISALIGNED = 2'b01,
        FAULT_RANGE      = 2'b10,
        FAULT_BAD_SIZE   = 2'b11
    } fault_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [1:0]      size;
        logic            we;
    } mem_req_t;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        fault_e          fault;
    } resp_t;

    // Bytes touched by an access; the illegal encoding is treated as a word.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_nbytes = 3'd1;
            SIZE_HALF: size_nbytes = 3'd2;
            default:   size_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of raw memory read data to a full register value.
module load_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] result_c
);

    always_comb begin
        result_c = data;
        case (size)
            SIZE_BYTE: result_c = {{24{sign_ext & data[7]}},  data[7:0]};
            SIZE_HALF: result_c = {{16{sign_ext & data[15]}}, data[15:0]};
            default:   result_c = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: address generation, fault checks, memory timing
// and registered response toward the execute stage.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES        = 256,
    parameter bit          ALLOW_MISALIGNED = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [XLEN-1:0] req_base,
    input  logic [XLEN-1:0] req_offset,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic [1:0]      resp_fault,
    output logic [XLEN-1:0] memory_address,
    output logic [XLEN-1:0] memory_in,
    output logic [1:0]      memory_size,
    output logic            memory_write_enable,
    input  logic [XLEN-1:0] memory_out
);

    state_e   state, state_next;
    mem_req_t mem_q, mem_next;
    resp_t    resp_q, resp_next;
    logic     resp_valid_q, resp_valid_next;
    logic     load_signed, load_signed_next;

    logic [XLEN-1:0] addr_c;
    logic [XLEN:0]   end_c;
    logic            misaligned_c;
    fault_e          fault_c;
    logic [XLEN-1:0] ext_c;

    assign req_ready           = (state == ST_IDLE) && !rst;
    assign resp_valid          = resp_valid_q;
    assign resp_rdata          = resp_q.rdata;
    assign resp_fault          = resp_q.fault;
    assign memory_address      = mem_q.addr;
    assign memory_in           = mem_q.wdata;
    assign memory_size         = mem_q.size;
    assign memory_write_enable = mem_q.we;

    // Effective address and fault classification (bad_size > misaligned > range).
    always_comb begin
        addr_c       = req_base + req_offset;
        end_c        = {1'b0, addr_c} + (XLEN+1)'(size_nbytes(req_size));
        misaligned_c = ((req_size == SIZE_HALF) && addr_c[0]) ||
                       ((req_size == SIZE_WORD) && (addr_c[1:0] != 2'b00));
        fault_c      = FAULT_NONE;
        if (req_size == SIZE_ILLEGAL) begin
            fault_c = FAULT_BAD_SIZE;
        end else if (!ALLOW_MISALIGNED && misaligned_c) begin
            fault_c = FAULT_MISALIGNED;
        end else if (end_c > (XLEN+1)'(MEM_BYTES)) begin
            fault_c = FAULT_RANGE;
        end
    end

    load_extend u_load_extend (
        .data     (memory_out),
        .size     (mem_q.size),
        .sign_ext (load_signed),
        .result_c (ext_c)
    );

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_next       = state;
        mem_next         = mem_q;
        mem_next.we      = 1'b0;
        resp_next        = resp_q;
        resp_valid_next  = resp_valid_q;
        load_signed_next = load_signed;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    mem_next.addr    = addr_c;
                    mem_next.wdata   = req_wdata;
                    mem_next.size    = req_size;
                    load_signed_next = req_signed;
                    if (fault_c != FAULT_NONE) begin
                        state_next      = ST_RESP;
                        resp_valid_next = 1'b1;
                        resp_next.rdata = '0;
                        resp_next.fault = fault_c;
                    end else if (req_write) begin
                        state_next  = ST_WRITE;
                        mem_next.we = 1'b1;
                    end else begin
                        state_next = ST_RD0;
                    end
                end
            end
            ST_WRITE: begin
                state_next      = ST_RESP;
                resp_valid_next = 1'b1;
                resp_next.rdata = '0;
                resp_next.fault = FAULT_NONE;
            end
            ST_RD0: state_next = ST_RD1;
            ST_RD1: state_next = ST_RD2;
            ST_RD2: begin
                state_next      = ST_RESP;
                resp_valid_next = 1'b1;
                resp_next.rdata = ext_c;
                resp_next.fault = FAULT_NONE;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next      = ST_IDLE;
                    resp_valid_next = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mem_q        <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            load_signed  <= 1'b0;
        end else begin
            state        <= state_next;
            mem_q        <= mem_next;
            resp_q       <= resp_next;
            resp_valid_q <= resp_valid_next;
            load_signed  <= load_signed_next;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (strict and misaligned-tolerant)
// each backed by a byte-addressed memory with two-edge read and one-edge write.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_write [NI];
    logic [1:0]  req_size  [NI];
    logic        req_signed[NI];
    logic [31:0] req_base  [NI];
    logic [31:0] req_offset[NI];
    logic [31:0] req_wdata [NI];
    logic        resp_valid[NI];
    logic        resp_ready[NI];
    logic [31:0] resp_rdata[NI];
    logic [1:0]  resp_fault[NI];
    logic [31:0] maddr     [NI];
    logic [31:0] min       [NI];
    logic [1:0]  msize     [NI];
    logic        mwe       [NI];
    logic [31:0] mout      [NI];

    load_store_unit #(.MEM_BYTES(256), .ALLOW_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]), .req_base(req_base[0]),
        .req_offset(req_offset[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
        .memory_address(maddr[0]), .memory_in(min[0]), .memory_size(msize[0]),
        .memory_write_enable(mwe[0]), .memory_out(mout[0])
    );

    load_store_unit #(.MEM_BYTES(256), .ALLOW_MISALIGNED(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]), .req_base(req_base[1]),
        .req_offset(req_offset[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
        .memory_address(maddr[1]), .memory_in(min[1]), .memory_size(msize[1]),
        .memory_write_enable(mwe[1]), .memory_out(mout[1])
    );

    // Memory models: little-endian, address wraps at 256, reads staged then output.
    logic [7:0]  mem     [NI][256];
    logic [31:0] staged  [NI];
    int          we_count[NI];

    function automatic int tb_nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            logic [31:0] rd;
            rd = '0;
            for (int i = 0; i < tb_nbytes(msize[g]); i++)
                rd[8*i +: 8] = mem[g][8'(maddr[g] + 32'(i))];
            if (mwe[g]) begin
                we_count[g] <= we_count[g] + 1;
                for (int i = 0; i < tb_nbytes(msize[g]); i++)
                    mem[g][8'(maddr[g] + 32'(i))] <= min[g][8*i +: 8];
            end
            staged[g] <= rd;
            mout[g]   <= staged[g];
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int we_before   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request and return #1 after its accept edge.
    task automatic issue(input int u, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                         input string tag);
        we_before     = we_count[u];
        req_write[u]  = wr;
        req_size[u]   = sz;
        req_signed[u] = sg;
        req_base[u]   = base;
        req_offset[u] = off;
        req_wdata[u]  = wd;
        req_valid[u]  = 1'b1;
        chk({tag, " req_ready"}, 32'(req_ready[u]), 32'd1);
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
    endtask

    // Wait (bounded) for the response, check it, then complete the handshake.
    task automatic finish(input int u, input int exp_lat, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_fault, input int exp_we, input string tag);
        int lat = 1;
        while (!resp_valid[u] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rdata"}, resp_rdata[u], exp_rdata);
        chk({tag, " fault"}, 32'(resp_fault[u]), 32'(exp_fault));
        chk({tag, " writes"}, 32'(we_count[u] - we_before), 32'(exp_we));
        resp_ready[u] = 1'b1;
        @(posedge clk); #1;
        resp_ready[u] = 1'b0;
        chk({tag, " resp_valid drop"}, 32'(resp_valid[u]), 32'd0);
        chk({tag, " write_enable idle"}, 32'(mwe[u]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int u = 0; u < NI; u++) begin
            req_valid[u] = 0; req_write[u] = 0; req_size[u] = 0; req_signed[u] = 0;
            req_base[u] = 0; req_offset[u] = 0; req_wdata[u] = 0; resp_ready[u] = 0;
            we_count[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready[0]), 32'd0);
        chk("rst resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst rdata", resp_rdata[0], 32'd0);
        chk("rst fault", 32'(resp_fault[0]), 32'd0);
        chk("rst addr", maddr[0], 32'd0);
        chk("rst min", min[0], 32'd0);
        chk("rst size", 32'(msize[0]), 32'd0);
        chk("rst we", 32'(mwe[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst req_ready", 32'(req_ready[0]), 32'd1);

        // Store word then load it back
        issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h4, 32'hDEADBEEF, "st_w");
        chk("st_w we", 32'(mwe[0]), 32'd1);
        chk("st_w addr", maddr[0], 32'h14);
        chk("st_w size", 32'(msize[0]), 32'd2);
        chk("st_w min", min[0], 32'hDEADBEEF);
        finish(0, 2, 32'h0, 2'b00, 1, "st_w");
        issue(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, "ld_w");
        finish(0, 4, 32'hDEADBEEF, 2'b00, 0, "ld_w");

        // Byte and half extension
        issue(0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h0, 32'h12345680, "st_b");
        finish(0, 2, 32'h0, 2'b00, 1, "st_b");
        issue(0, 1'b0, 2'b00, 1'b1, 32'h1F, 32'h1, 32'h0, "ld_b_s");
        finish(0, 4, 32'hFFFFFF80, 2'b00, 0, "ld_b_s");
        issue(0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0, "ld_b_u");
        finish(0, 4, 32'h00000080, 2'b00, 0, "ld_b_u");
        issue(0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h0, 32'hAAAA7FFF, "st_h");
        finish(0, 2, 32'h0, 2'b00, 1, "st_h");
        issue(0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0, "ld_h_s_pos");
        finish(0, 4, 32'h00007FFF, 2'b00, 0, "ld_h_s_pos");
        issue(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0, "ld_b_hi");
        finish(0, 4, 32'h0000007F, 2'b00, 0, "ld_b_hi");
        issue(0, 1'b1, 2'b01, 1'b0, 32'h30, 32'h0, 32'h000080F0, "st_h2");
        finish(0, 2, 32'h0, 2'b00, 1, "st_h2");
        issue(0, 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h0, "ld_h_s_neg");
        finish(0, 4, 32'hFFFF80F0, 2'b00, 0, "ld_h_s_neg");
        issue(0, 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'h0, "ld_h_u");
        finish(0, 4, 32'h000080F0, 2'b00, 0, "ld_h_u");

        // Faults and range boundaries
        issue(0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, "ld_h_mis");
        finish(0, 1, 32'h0, 2'b01, 0, "ld_h_mis");
        issue(0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0, 32'hFFFF, "st_h_mis");
        finish(0, 1, 32'h0, 2'b01, 0, "st_h_mis");
        issue(0, 1'b0, 2'b11, 1'b0, 32'hFE, 32'h0, 32'h0, "ld_badsz");
        finish(0, 1, 32'h0, 2'b11, 0, "ld_badsz");
        issue(0, 1'b0, 2'b10, 1'b0, 32'hFE, 32'h0, 32'h0, "ld_w_mis_fe");
        finish(0, 1, 32'h0, 2'b01, 0, "ld_w_mis_fe");
        issue(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, "ld_w_range");
        finish(0, 1, 32'h0, 2'b10, 0, "ld_w_range");
        issue(0, 1'b0, 2'b10, 1'b0, 32'hFFFFFFF0, 32'hC, 32'h0, "ld_w_range33");
        finish(0, 1, 32'h0, 2'b10, 0, "ld_w_range33");
        issue(0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h0, 32'h55, "st_badsz");
        finish(0, 1, 32'h0, 2'b11, 0, "st_badsz");
        issue(0, 1'b1, 2'b10, 1'b0, 32'hFC, 32'h0, 32'h01020304, "st_w_top");
        finish(0, 2, 32'h0, 2'b00, 1, "st_w_top");
        issue(0, 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 32'h0, "ld_w_top");
        finish(0, 4, 32'h01020304, 2'b00, 0, "ld_w_top");
        issue(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, "ld_b_ff");
        finish(0, 4, 32'h00000001, 2'b00, 0, "ld_b_ff");
        issue(0, 1'b0, 2'b01, 1'b0, 32'hFE, 32'h0, 32'h0, "ld_h_fe");
        finish(0, 4, 32'h00000102, 2'b00, 0, "ld_h_fe");
        issue(0, 1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0000005A, "st_b_wrap");
        chk("st_b_wrap addr", maddr[0], 32'h0);
        finish(0, 2, 32'h0, 2'b00, 1, "st_b_wrap");
        issue(0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, "ld_b_wrap");
        finish(0, 4, 32'h0000005A, 2'b00, 0, "ld_b_wrap");

        // Backpressure: response held, competing store must be ignored
        issue(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, "bp_ld");
        repeat (3) begin @(posedge clk); #1; end
        chk("bp resp_valid", 32'(resp_valid[0]), 32'd1);
        req_write[0] = 1'b1; req_size[0] = 2'b10; req_base[0] = 32'h14;
        req_offset[0] = 32'h0; req_wdata[0] = 32'h0; req_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp hold valid", 32'(resp_valid[0]), 32'd1);
            chk("bp hold rdata", resp_rdata[0], 32'hDEADBEEF);
            chk("bp hold fault", 32'(resp_fault[0]), 32'd0);
            chk("bp req_ready", 32'(req_ready[0]), 32'd0);
            chk("bp we", 32'(mwe[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        chk("bp drop", 32'(resp_valid[0]), 32'd0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, "bp_next");
        finish(0, 4, 32'hDEADBEEF, 2'b00, 0, "bp_next");

        // Reset while a load sits in RD1
        issue(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, "rst_ld");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_ld resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_ld req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_ld addr", maddr[0], 32'd0);
        chk("rst_ld min", min[0], 32'd0);
        chk("rst_ld size", 32'(msize[0]), 32'd0);
        chk("rst_ld we", 32'(mwe[0]), 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_ld no resp", 32'(resp_valid[0]), 32'd0);

        // Reset on the WRITE edge still commits the store
        issue(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, "rst_st");
        chk("rst_st we", 32'(mwe[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_st writes", 32'(we_count[0] - we_before), 32'd1);
        chk("rst_st we clr", 32'(mwe[0]), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_st no resp", 32'(resp_valid[0]), 32'd0);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, "rst_st_ld");
        finish(0, 4, 32'hCAFEF00D, 2'b00, 0, "rst_st_ld");

        // Misaligned-tolerant instance
        issue(1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h3, 32'h11223344, "ma_st_w");
        finish(1, 2, 32'h0, 2'b00, 1, "ma_st_w");
        issue(1, 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 32'h0, "ma_ld_w");
        finish(1, 4, 32'h11223344, 2'b00, 0, "ma_ld_w");
        issue(1, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0000BEEF, "ma_st_h");
        finish(1, 2, 32'h0, 2'b00, 1, "ma_st_h");
        issue(1, 1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 32'h0, "ma_ld_h");
        finish(1, 4, 32'hFFFFBEEF, 2'b00, 0, "ma_ld_h");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
